// File: rtl/ddr3_frame_fetch_ctrl_if.sv
// Bundles the CSR, frame sync, FIFO level and DDR3 Avalon read port seen by
// ddr3_frame_fetch_ctrl.
//   master : the fetch controller (drives Avalon requests, CSR read data, fifo_wr)
//   slave  : the surrounding system (CSR host, VGA sync, FIFO, DDR3 controller)
interface ddr3_frame_fetch_ctrl_if #(
    parameter int ADDR_W = 26,
    parameter int CNT_W  = 9
);
    logic              csr_read;
    logic              csr_write;
    logic [7:0]        csr_addr;
    logic [31:0]       csr_wr_data;
    logic [31:0]       csr_rd_data;
    logic              frame_start;
    logic [CNT_W-1:0]  fifo_used;
    logic              ddr3_avl_ready;
    logic              ddr3_avl_read_req;
    logic              ddr3_avl_burstbegin;
    logic [ADDR_W-1:0] ddr3_avl_addr;
    logic [2:0]        ddr3_avl_size;
    logic              ddr3_avl_read_data_valid;
    logic              fifo_wr;

    modport master (
        input  csr_read, csr_write, csr_addr, csr_wr_data, frame_start, fifo_used,
               ddr3_avl_ready, ddr3_avl_read_data_valid,
        output csr_rd_data, ddr3_avl_read_req, ddr3_avl_burstbegin, ddr3_avl_addr,
               ddr3_avl_size, fifo_wr
    );

    modport slave (
        output csr_read, csr_write, csr_addr, csr_wr_data, frame_start, fifo_used,
               ddr3_avl_ready, ddr3_avl_read_data_valid,
        input  csr_rd_data, ddr3_avl_read_req, ddr3_avl_burstbegin, ddr3_avl_addr,
               ddr3_avl_size, fifo_wr
    );
endinterface

// File: rtl/ddr3_frame_fetch_ctrl.sv
// Frame fetch controller: once per video frame, streams FRAME_WORDS 128-bit
// words starting at BASE out of DDR3 with Avalon burst reads into the pixel
// FIFO. Requests are credit limited so that FIFO contents plus words still in
// flight never exceed FIFO_DEPTH.
// Ports:
//   clk, reset_n : DDR3 user clock, async active-low reset
//   bus          : master side of ddr3_frame_fetch_ctrl_if (CSR, frame_start,
//                  fifo_used, Avalon read port, fifo_wr)
// CSR map (word index): 0 CTRL[0]=enable, 1 BASE, 2 FRAME_WORDS[23:0],
//   3 STATUS = {underrun, overrun, busy, 0}; underrun/overrun are write-1-clear.
module ddr3_frame_fetch_ctrl #(
    parameter int ADDR_W     = 26,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 256,
    parameter int CNT_W      = 9
) (
    input logic clk,
    input logic reset_n,
    ddr3_frame_fetch_ctrl_if.master bus
);
    localparam int SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic              enable, underrun, overrun, started;
    logic [ADDR_W-1:0] base, cur_addr, addr_eff, req_addr;
    logic [23:0]       frame_words, remaining, rem_eff;
    logic [CNT_W-1:0]  outstanding, out_eff;
    logic              req_q, bb_q, accept, launch, busy, ret_dec;
    logic [2:0]        req_size, n_burst;
    logic [SUM_W-1:0]  credit_need;
    logic [31:0]       rd_mux;
    logic              unused_ok;

    assign unused_ok = &{1'b0, bus.csr_wr_data};

    assign accept = req_q && bus.ddr3_avl_ready;
    assign busy   = (state == ISSUE) || (state == DRAIN);
    // Returns with nothing outstanding belong to bursts issued before a reset.
    assign ret_dec = bus.ddr3_avl_read_data_valid && (outstanding != '0);

    // Values as they stand after this cycle's acceptance, so a new request can
    // be launched in the same cycle the previous one is taken (back-to-back).
    always_comb begin
        rem_eff     = accept ? remaining - 24'(req_size) : remaining;
        addr_eff    = accept ? cur_addr + ADDR_W'(req_size) : cur_addr;
        out_eff     = outstanding + (accept ? CNT_W'(req_size) : '0)
                      - (ret_dec ? CNT_W'(1) : '0);
        n_burst     = (rem_eff < 24'(BURST_LEN)) ? rem_eff[2:0] : 3'(BURST_LEN);
        credit_need = SUM_W'(bus.fifo_used) + SUM_W'(out_eff) + SUM_W'(n_burst);
        launch      = (state == ISSUE) && enable && (!req_q || accept) &&
                      (rem_eff != '0) && (credit_need <= SUM_W'(FIFO_DEPTH));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (enable && frame_words != '0) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (!enable) state_nxt = IDLE;
                        else if (bus.frame_start) state_nxt = ISSUE;
            // A held request is never abandoned; leave only once it is taken.
            ISSUE:      if ((rem_eff == '0 || !enable) && (!req_q || accept))
                            state_nxt = DRAIN;
            DRAIN:      if (outstanding == '0) state_nxt = enable ? WAIT_FRAME : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr    <= '0;
            remaining   <= '0;
            started     <= 1'b0;
            outstanding <= '0;
            req_q       <= 1'b0;
            bb_q        <= 1'b0;
            req_addr    <= '0;
            req_size    <= '0;
        end else begin
            outstanding <= out_eff;
            if (state == WAIT_FRAME && enable && bus.frame_start) begin
                cur_addr  <= base;
                remaining <= frame_words;
                started   <= 1'b0;
            end else if (state == ISSUE) begin
                cur_addr  <= addr_eff;
                remaining <= rem_eff;
                if (accept) started <= 1'b1;
            end
            if (launch) begin
                req_q    <= 1'b1;
                bb_q     <= 1'b1;
                req_addr <= addr_eff;
                req_size <= n_burst;
            end else begin
                bb_q <= 1'b0;
                if (accept) req_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.csr_addr)
            8'd0:    rd_mux = {31'b0, enable};
            8'd1:    rd_mux = 32'(base);
            8'd2:    rd_mux = {8'b0, frame_words};
            8'd3:    rd_mux = {28'b0, underrun, overrun, busy, 1'b0};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable          <= 1'b0;
            base            <= '0;
            frame_words     <= '0;
            underrun        <= 1'b0;
            overrun         <= 1'b0;
            bus.csr_rd_data <= '0;
        end else begin
            if (bus.csr_write) begin
                case (bus.csr_addr)
                    8'd0:    enable      <= bus.csr_wr_data[0];
                    8'd1:    base        <= bus.csr_wr_data[ADDR_W-1:0];
                    8'd2:    frame_words <= bus.csr_wr_data[23:0];
                    default: ;
                endcase
            end
            // Setting wins over a simultaneous write-1-clear.
            overrun <= (bus.frame_start && busy) ||
                       (overrun && !(bus.csr_write && bus.csr_addr == 8'd3 && bus.csr_wr_data[2]));
            // Starved only counts once this frame has fetched something.
            underrun <= (state == ISSUE && started && bus.fifo_used == '0 && outstanding == '0) ||
                        (underrun && !(bus.csr_write && bus.csr_addr == 8'd3 && bus.csr_wr_data[3]));
            bus.csr_rd_data <= bus.csr_read ? rd_mux : '0;
        end
    end

    assign bus.ddr3_avl_read_req   = req_q;
    assign bus.ddr3_avl_burstbegin = bb_q;
    assign bus.ddr3_avl_addr       = req_addr;
    assign bus.ddr3_avl_size       = req_size;
    assign bus.fifo_wr             = bus.ddr3_avl_read_data_valid;
endmodule

// File: tb/tb_ddr3_frame_fetch_ctrl.sv
// Bench for ddr3_frame_fetch_ctrl: CSR vector table, then frame sequences.
// Expected Avalon requests are queued per frame and popped as the DUT's
// requests are accepted; a simple responder returns one word per cycle.
module tb_ddr3_frame_fetch_ctrl;
    localparam int ADDR_W = 26, CNT_W = 9, FIFO_DEPTH = 256, BURST_LEN = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddr3_frame_fetch_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

    ddr3_frame_fetch_ctrl #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
                            .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct { logic [ADDR_W-1:0] addr; logic [2:0] size; } req_t;
    typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; } csr_vec_t;

    req_t     exp_q[$];
    csr_vec_t vecs[10];

    int n_checks = 0, n_fail = 0;
    int pend = 0, accepts = 0, bb_count = 0, stall_cycles = 0;
    logic prev_req = 1'b0, prev_acc = 1'b0, forbid = 1'b0, resp_en = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [2:0]        prev_size = '0;
    logic [31:0]       rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: monitor + responder at negedge, return 1 time unit after posedge.
    task automatic tick();
        req_t e;
        logic held;
        @(negedge clk);
        chk("fifo_wr", {31'b0, bus.fifo_wr}, {31'b0, bus.ddr3_avl_read_data_valid});
        if (forbid) chk("no_req_after_disable", {31'b0, bus.ddr3_avl_read_req}, 32'd0);
        if (bus.ddr3_avl_read_req) begin
            held = prev_req && !prev_acc;
            chk("burstbegin", {31'b0, bus.ddr3_avl_burstbegin}, {31'b0, !held});
            if (held) begin
                chk("held_addr", 32'(bus.ddr3_avl_addr), 32'(prev_addr));
                chk("held_size", 32'(bus.ddr3_avl_size), 32'(prev_size));
            end
            if (bus.ddr3_avl_burstbegin) bb_count++;
            if (!bus.ddr3_avl_ready) stall_cycles++;
            else begin
                accepts++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h size %0d, expected no request",
                             bus.ddr3_avl_addr, bus.ddr3_avl_size);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_addr", 32'(bus.ddr3_avl_addr), 32'(e.addr));
                    chk("req_size", 32'(bus.ddr3_avl_size), 32'(e.size));
                end
            end
        end else begin
            chk("burstbegin_idle", {31'b0, bus.ddr3_avl_burstbegin}, 32'd0);
        end
        prev_req  = bus.ddr3_avl_read_req;
        prev_acc  = bus.ddr3_avl_read_req && bus.ddr3_avl_ready;
        prev_addr = bus.ddr3_avl_addr;
        prev_size = bus.ddr3_avl_size;
        // Responder: the word driven last cycle was consumed at the last posedge.
        if (bus.ddr3_avl_read_data_valid) pend--;
        bus.ddr3_avl_read_data_valid = resp_en && (pend > 0);
        if (prev_acc) pend += int'(bus.ddr3_avl_size);
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        bus.csr_write = 1'b1; bus.csr_addr = a; bus.csr_wr_data = d;
        tick();
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
        bus.csr_read = 1'b1; bus.csr_addr = a;
        tick();
        bus.csr_read = 1'b0;
        d = bus.csr_rd_data;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic push_frame(input logic [ADDR_W-1:0] b, input int words);
        req_t r;
        while (words > 0) begin
            r.size = 3'((words < BURST_LEN) ? words : BURST_LEN);
            r.addr = b;
            exp_q.push_back(r);
            b = b + ADDR_W'(r.size);
            words -= int'(r.size);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i = 0;
        while ((exp_q.size() != 0 || pend != 0) && i < limit) begin tick(); i++; end
        chk(name, {31'b0, i < limit}, 32'd1);
        tick(); tick();
    endtask

    task automatic wait_accepts(input string name, input int target, input int limit);
        int i = 0;
        while (accepts < target && i < limit) begin tick(); i++; end
        chk(name, {31'b0, i < limit}, 32'd1);
    endtask

    task automatic chk_status(input string name, input logic [31:0] exp);
        logic [31:0] s;
        csr_rd(8'd3, s);
        chk(name, s, exp);
    endtask

    initial begin
        bus.csr_read = 0; bus.csr_write = 0; bus.csr_addr = 0; bus.csr_wr_data = 0;
        bus.frame_start = 0; bus.fifo_used = 0; bus.ddr3_avl_ready = 1;
        bus.ddr3_avl_read_data_valid = 0;

        vecs[0] = '{1'b0, 8'd0, 32'h0,          32'h0};
        vecs[1] = '{1'b0, 8'd1, 32'h0,          32'h0};
        vecs[2] = '{1'b0, 8'd2, 32'h0,          32'h0};
        vecs[3] = '{1'b0, 8'd3, 32'h0,          32'h0};
        vecs[4] = '{1'b1, 8'd1, 32'hFFFF_FFFF,  32'h03FF_FFFF};
        vecs[5] = '{1'b1, 8'd2, 32'hFFFF_FFFF,  32'h00FF_FFFF};
        vecs[6] = '{1'b1, 8'd5, 32'h0000_1234,  32'h0};
        vecs[7] = '{1'b1, 8'd3, 32'h0000_000F,  32'h0};
        vecs[8] = '{1'b1, 8'd1, 32'h0000_0100,  32'h100};
        vecs[9] = '{1'b1, 8'd2, 32'd16,         32'd16};

        // Reset state
        repeat (3) tick();
        chk("rst_req",   {31'b0, bus.ddr3_avl_read_req},   32'd0);
        chk("rst_bb",    {31'b0, bus.ddr3_avl_burstbegin}, 32'd0);
        chk("rst_addr",  32'(bus.ddr3_avl_addr),           32'd0);
        chk("rst_size",  32'(bus.ddr3_avl_size),           32'd0);
        chk("rst_rdata", bus.csr_rd_data,                  32'd0);
        reset_n = 1'b1;
        tick();

        // CSR table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) csr_wr(vecs[i].addr, vecs[i].wdata);
            csr_rd(vecs[i].addr, rd);
            chk($sformatf("csr_vec%0d", i), rd, vecs[i].exp);
        end

        // 16-word frame: four size-4 bursts
        csr_wr(8'd0, 32'd1);
        tick();
        push_frame(26'h100, 16);
        accepts = 0; bb_count = 0;
        pulse_frame();
        wait_drain("t1_drain", 200);
        chk("t1_accepts", accepts, 4);
        chk("t1_bb_pulses", bb_count, 4);
        chk_status("t1_status", 32'h0);

        // 10-word frame: 4,4,2 then DRAIN until all words return
        csr_wr(8'd2, 32'd10);
        resp_en = 1'b0;
        push_frame(26'h100, 10);
        accepts = 0;
        pulse_frame();
        wait_accepts("t2_accept_wait", 3, 50);
        repeat (3) tick();
        chk("t2_accepts", accepts, 3);
        chk_status("t2_status_drain", 32'h2);
        resp_en = 1'b1;
        wait_drain("t2_drain", 200);
        chk_status("t2_status_done", 32'h0);

        // Ready stall on second request
        csr_wr(8'd2, 32'd16);
        bus.fifo_used = 9'd8;
        push_frame(26'h100, 16);
        accepts = 0; bb_count = 0; stall_cycles = 0;
        pulse_frame();
        wait_accepts("t3_accept_wait", 1, 50);
        bus.ddr3_avl_ready = 1'b0;
        repeat (5) tick();
        bus.ddr3_avl_ready = 1'b1;
        wait_drain("t3_drain", 200);
        chk("t3_stalls", stall_cycles, 5);
        chk("t3_bb_pulses", bb_count, 4);
        chk("t3_accepts", accepts, 4);
        chk_status("t3_status", 32'h0);

        // Credit limit at FIFO_DEPTH boundary
        bus.fifo_used = 9'(FIFO_DEPTH - 4);
        resp_en = 1'b0;
        push_frame(26'h100, 16);
        accepts = 0;
        pulse_frame();
        repeat (20) tick();
        chk("t4_one_burst", accepts, 1);
        bus.fifo_used = 9'(FIFO_DEPTH - 8);
        repeat (10) tick();
        chk("t4_two_bursts", accepts, 2);
        bus.fifo_used = 9'd8;
        wait_accepts("t4_accept_wait", 4, 50);
        resp_en = 1'b1;
        wait_drain("t4_drain", 200);
        chk_status("t4_status", 32'h0);

        // Underrun: FIFO empty and nothing in flight while a request stalls
        bus.fifo_used = 9'd0;
        csr_wr(8'd2, 32'd8);
        push_frame(26'h100, 8);
        accepts = 0;
        pulse_frame();
        wait_accepts("t5_accept_wait", 1, 50);
        bus.ddr3_avl_ready = 1'b0;
        repeat (10) tick();
        chk_status("t5_underrun", 32'hA);
        bus.fifo_used = 9'd8;
        csr_wr(8'd3, 32'h8);
        chk_status("t5_underrun_clr", 32'h2);
        bus.ddr3_avl_ready = 1'b1;
        wait_drain("t5_drain", 200);
        chk_status("t5_status", 32'h0);

        // Overrun: frame_start while busy is flagged and ignored
        csr_wr(8'd2, 32'd16);
        resp_en = 1'b0;
        push_frame(26'h100, 16);
        accepts = 0;
        pulse_frame();
        wait_accepts("t6_accept_wait", 1, 50);
        pulse_frame();
        wait_accepts("t6_accept_wait4", 4, 50);
        tick();
        chk_status("t6_overrun", 32'h6);
        csr_wr(8'd3, 32'h4);
        chk_status("t6_overrun_clr", 32'h2);
        resp_en = 1'b1;
        wait_drain("t6_drain", 200);
        chk("t6_accepts", accepts, 4);
        chk_status("t6_status", 32'h0);

        // Disable while a request is held
        bus.ddr3_avl_ready = 1'b0;
        push_frame(26'h100, 4);
        accepts = 0;
        pulse_frame();
        begin
            int i = 0;
            while (!bus.ddr3_avl_read_req && i < 20) begin tick(); i++; end
            chk("t7_req_wait", {31'b0, i < 20}, 32'd1);
        end
        csr_wr(8'd0, 32'd0);
        tick();
        chk("t7_still_held", {31'b0, bus.ddr3_avl_read_req}, 32'd1);
        bus.ddr3_avl_ready = 1'b1;
        tick();
        forbid = 1'b1;
        wait_drain("t7_drain", 200);
        pulse_frame();
        repeat (10) tick();
        forbid = 1'b0;
        chk("t7_accepts", accepts, 1);
        chk_status("t7_status_idle", 32'h0);

        // Async reset mid-frame; late returns must not corrupt credit
        csr_wr(8'd0, 32'd1);
        csr_wr(8'd2, 32'd16);
        resp_en = 1'b0;
        push_frame(26'h100, 16);
        accepts = 0;
        pulse_frame();
        wait_accepts("t8_accept_wait", 2, 50);
        #2 reset_n = 1'b0;
        #1;
        chk("t8_rst_req",  {31'b0, bus.ddr3_avl_read_req},   32'd0);
        chk("t8_rst_bb",   {31'b0, bus.ddr3_avl_burstbegin}, 32'd0);
        chk("t8_rst_size", 32'(bus.ddr3_avl_size),           32'd0);
        exp_q.delete();
        prev_req = 1'b0; prev_acc = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        resp_en = 1'b1;
        wait_drain("t8_late_returns", 100);
        csr_rd(8'd1, rd);
        chk("t8_base_cleared", rd, 32'h0);
        csr_wr(8'd1, 32'h100);
        csr_wr(8'd2, 32'd4);
        csr_wr(8'd0, 32'd1);
        bus.fifo_used = 9'(FIFO_DEPTH - 4);
        tick();
        push_frame(26'h100, 4);
        accepts = 0;
        pulse_frame();
        wait_drain("t8_refetch", 100);
        chk("t8_accepts", accepts, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
